// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and load-use detection.
// Define ID_EX_FORWARDING_EN to enable the EX/MEM and MEM/WB forward muxes.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic [4:0]      ex_mem_rd,
  input  logic            ex_mem_reg_write,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [4:0]      mem_wb_rd,
  input  logic            mem_wb_reg_write,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic [XLEN-1:0] alu_data1,
  output logic [XLEN-1:0] alu_data2,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            load_use_hazard
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_ONES = 4'b1111
  } alu_ctl_e;

  alu_ctl_e        ctl_d, ctl_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic [4:0]      rs1_q, rs2_q;
  logic            alu_src_q;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // funct7_5 only selects SUB for register-register ops; addi never subtracts.
  always_comb begin
    ctl_d = ALU_ADD;
    case (id_alu_op)
      2'b00: ctl_d = ALU_ADD;
      2'b01: ctl_d = ALU_SUB;
      2'b10: begin
        case (id_funct3)
          3'b000:  ctl_d = (id_funct7_5 && !id_alu_src) ? ALU_SUB : ALU_ADD;
          3'b111:  ctl_d = ALU_AND;
          3'b110:  ctl_d = ALU_OR;
          default: ctl_d = ALU_ONES;
        endcase
      end
      default: ctl_d = ALU_ONES;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      ex_rd         <= '0;
      alu_src_q     <= 1'b0;
      ctl_q         <= ALU_ADD;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      ex_rd         <= '0;
      alu_src_q     <= 1'b0;
      ctl_q         <= ALU_ADD;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      rs1_data_q    <= id_rs1_data;
      rs2_data_q    <= id_rs2_data;
      imm_q         <= id_imm;
      rs1_q         <= id_rs1;
      rs2_q         <= id_rs2;
      ex_rd         <= id_rd;
      alu_src_q     <= id_alu_src;
      ctl_q         <= ctl_d;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs1_q))
      fwd_rs1 = ex_mem_result;
    else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs1_q))
      fwd_rs1 = mem_wb_data;
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs2_q))
      fwd_rs2 = ex_mem_result;
    else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs2_q))
      fwd_rs2 = mem_wb_data;
  end

  assign load_use_hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                           ((ex_rd == id_rs1) | (ex_rd == id_rs2));
`else
  logic ex_hit, exmem_hit, unused_fwd;

  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  // Without forwarding every RAW dependency on EX or EX/MEM must stall.
  assign ex_hit    = ex_valid & ex_reg_write & (ex_rd != '0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign exmem_hit = ex_mem_reg_write & (ex_mem_rd != '0) &
                     ((ex_mem_rd == id_rs1) | (ex_mem_rd == id_rs2));
  assign load_use_hazard = id_valid & (ex_hit | exmem_hit |
                           (ex_valid & ex_mem_read & (ex_rd != '0) &
                            ((ex_rd == id_rs1) | (ex_rd == id_rs2))));
  assign unused_fwd = ^{ex_mem_result, mem_wb_rd, mem_wb_reg_write, mem_wb_data};
`endif

  assign alu_data1     = fwd_rs1;
  assign alu_data2     = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign alu_control   = ctl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;

  logic            clk, reset, stall, flush;
  logic            id_valid, id_alu_src, id_funct7_5;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [1:0]      id_alu_op;
  logic [2:0]      id_funct3;
  logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [4:0]      ex_mem_rd, mem_wb_rd;
  logic            ex_mem_reg_write, mem_wb_reg_write;
  logic [XLEN-1:0] ex_mem_result, mem_wb_data;
  logic [XLEN-1:0] alu_data1, alu_data2, ex_store_data, ex_pc;
  logic [3:0]      alu_control;
  logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]      ex_rd;
  logic            load_use_hazard;

  int vectors = 0;
  int miscompares = 0;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_result(ex_mem_result),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_data(mem_wb_data),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = 2'b00; id_alu_src = 1'b0;
    id_funct3 = 3'b000; id_funct7_5 = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
  endtask

  task automatic decode(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic src, input logic [3:0] exp);
    id_alu_op = op; id_funct3 = f3; id_funct7_5 = f7; id_alu_src = src;
    tick();
    check(tag, 32'(alu_control), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_clear();
    ex_mem_rd = '0; ex_mem_reg_write = 1'b0; ex_mem_result = '0;
    mem_wb_rd = '0; mem_wb_reg_write = 1'b0; mem_wb_data = '0;
    #12;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctl", 32'(alu_control), 32'h2);
    check("rst_pc", ex_pc, 32'h0);
    check("rst_data1", alu_data1, 32'h0);
    check("rst_store", ex_store_data, 32'h0);
    check("rst_hazard", 32'(load_use_hazard), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic load and decode table
    id_valid = 1'b1; id_pc = 32'h100; id_reg_write = 1'b1; id_rd = 5'd2;
    decode("dec_add", 2'b00, 3'b000, 1'b0, 1'b0, 4'b0010);
    check("load_valid", 32'(ex_valid), 32'd1);
    check("load_pc", ex_pc, 32'h100);
    check("load_rd", 32'(ex_rd), 32'd2);
    decode("dec_sub", 2'b01, 3'b000, 1'b0, 1'b0, 4'b0110);
    decode("dec_rsub", 2'b10, 3'b000, 1'b1, 1'b0, 4'b0110);
    decode("dec_addi", 2'b10, 3'b000, 1'b1, 1'b1, 4'b0010);
    decode("dec_radd", 2'b10, 3'b000, 1'b0, 1'b0, 4'b0010);
    decode("dec_and", 2'b10, 3'b111, 1'b0, 1'b0, 4'b0000);
    decode("dec_or", 2'b10, 3'b110, 1'b0, 1'b0, 4'b0001);
    decode("dec_f3other", 2'b10, 3'b001, 1'b0, 1'b0, 4'b1111);
    decode("dec_op11", 2'b11, 3'b000, 1'b0, 1'b0, 4'b1111);

    // Operand 2 source select
    id_alu_op = 2'b00; id_alu_src = 1'b1; id_imm = 32'h1234; id_rs2 = 5'd9; id_rs2_data = 32'hABCD;
    tick();
    check("src_imm", alu_data2, 32'h1234);
    check("src_imm_store", ex_store_data, 32'hABCD);
    id_alu_src = 1'b0;
    tick();
    check("src_reg", alu_data2, 32'hABCD);

    // Forward priority on rs1
    id_rs1 = 5'd5; id_rs1_data = 32'h55; id_rs2 = 5'd6; id_rs2_data = 32'h66; id_rd = 5'd10;
    tick();
    ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1; ex_mem_result = 32'h11;
    mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1; mem_wb_data = 32'h22;
    #1;
    check("fwd_both", alu_data1, FWD ? 32'h11 : 32'h55);
    ex_mem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", alu_data1, FWD ? 32'h22 : 32'h55);
    mem_wb_rd = 5'd6;
    #1;
    check("fwd_store", ex_store_data, FWD ? 32'h22 : 32'h66);
    check("fwd_data2", alu_data2, FWD ? 32'h22 : 32'h66);
    id_rs1 = 5'd0; id_rs1_data = 32'h77; id_rs2 = 5'd0; id_rs2_data = 32'h88;
    ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b1; mem_wb_rd = 5'd0; mem_wb_reg_write = 1'b1;
    tick();
    check("fwd_x0", alu_data1, 32'h77);
    check("fwd_x0_rs2", ex_store_data, 32'h88);

    // Asynchronous reset mid-cycle
    ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_pc", ex_pc, 32'h0);
    check("arst_ctl", 32'(alu_control), 32'h2);
    check("arst_data1", alu_data1, 32'h0);
    check("arst_rw", 32'(ex_reg_write), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    id_alu_op = 2'b10; id_funct3 = 3'b110;
    tick();
    check("post_rst_or", 32'(alu_control), 32'h1);

    // Load-use hazard then flush
    id_clear();
    id_valid = 1'b1; id_pc = 32'h140; id_mem_read = 1'b1; id_reg_write = 1'b1;
    id_mem_to_reg = 1'b1; id_rd = 5'd7;
    tick();
    check("lw_memread", 32'(ex_mem_read), 32'd1);
    check("lw_mem2reg", 32'(ex_mem_to_reg), 32'd1);
    id_clear();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd8;
    #1;
    check("lu_nomatch", 32'(load_use_hazard), 32'd0);
    id_rs2 = 5'd7;
    #1;
    check("lu_hit", 32'(load_use_hazard), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("lu_flush_valid", 32'(ex_valid), 32'd0);
    check("lu_flush_haz", 32'(load_use_hazard), 32'd0);

    // Stall hold then stall+flush bubble
    id_clear();
    id_valid = 1'b1; id_pc = 32'h200; id_alu_op = 2'b01; id_mem_write = 1'b1; id_rd = 5'd4;
    tick();
    stall = 1'b1;
    id_pc = 32'h300; id_alu_op = 2'b00; id_mem_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", ex_pc, 32'h200);
      check("stall_ctl", 32'(alu_control), 32'h6);
      check("stall_mw", 32'(ex_mem_write), 32'd1);
    end
    flush = 1'b1;
    tick();
    check("sf_valid", 32'(ex_valid), 32'd0);
    check("sf_pc", ex_pc, 32'h0);
    check("sf_ctl", 32'(alu_control), 32'h2);
    check("sf_mw", 32'(ex_mem_write), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // RAW against a non-load in EX
    id_clear();
    id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd3; id_rs1 = 5'd4; id_rs1_data = 32'h44;
    tick();
    ex_mem_rd = 5'd4; ex_mem_reg_write = 1'b1; ex_mem_result = 32'h99;
    id_clear();
    id_valid = 1'b1; id_rs1 = 5'd3;
    #1;
    check("raw_hazard", 32'(load_use_hazard), FWD ? 32'd0 : 32'd1);
    check("raw_data1", alu_data1, FWD ? 32'h99 : 32'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
